// File: rtl/hud_bcd_converter.sv
// Converts the HUD score (8-bit) and clamped player blood (10-bit) to packed 3-digit BCD
// using one shared iterative double-dabble engine. Both results publish on the same edge.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a frame trigger, outputs hold last result
// CONV_S  | shifting the captured score through the dabble register
// CONV_B  | shifting the captured blood, publishes both results at end
module hud_bcd_converter #(
  parameter int ITER_W      = 10,
  parameter int BLOOD_CLAMP = 999
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        game_frame_clk_rising_edge,
  input  logic [7:0]  Score_In,
  input  logic [9:0]  Blood_In,
  output logic [11:0] Score_BCD,
  output logic [11:0] Blood_BCD,
  output logic        Valid,
  output logic        Busy,
  output logic        Overrun
);

  localparam int SR_W  = 12 + ITER_W;
  localparam int CNT_W = (ITER_W > 1) ? $clog2(ITER_W) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV_S = 2'd1;
  localparam logic [1:0] ST_CONV_B = 2'd2;

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER_W - 1);
  localparam logic [9:0]       CLAMP_V   = 10'(BLOOD_CLAMP);

  logic [1:0]        state;
  logic [CNT_W-1:0]  iter;
  logic [SR_W-1:0]   shift_reg;
  logic [SR_W-1:0]   corrected;
  logic [SR_W-1:0]   shifted;
  logic [ITER_W-1:0] blood_hold;
  logic [11:0]       score_hold;
  logic [ITER_W-1:0] score_ext;
  logic [ITER_W-1:0] blood_ext;
  logic [9:0]        blood_clamped;

  always_comb begin
    blood_clamped = (Blood_In > CLAMP_V) ? CLAMP_V : Blood_In;
    score_ext = '0;
    score_ext[7:0] = Score_In;
    blood_ext = '0;
    blood_ext[9:0] = blood_clamped;
  end

  // All three digit corrections look at the pre-shift nibble values.
  always_comb begin
    corrected = shift_reg;
    for (int d = 0; d < 3; d++) begin
      if (shift_reg[ITER_W + 4*d +: 4] >= 4'd5)
        corrected[ITER_W + 4*d +: 4] = shift_reg[ITER_W + 4*d +: 4] + 4'd3;
    end
    shifted = {corrected[SR_W-2:0], 1'b0};
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      iter       <= '0;
      shift_reg  <= '0;
      blood_hold <= '0;
      score_hold <= '0;
      Score_BCD  <= '0;
      Blood_BCD  <= '0;
      Valid      <= 1'b0;
      Busy       <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (game_frame_clk_rising_edge && (state != ST_IDLE))
        Overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (game_frame_clk_rising_edge) begin
            shift_reg  <= {12'b0, score_ext};
            blood_hold <= blood_ext;
            iter       <= '0;
            Busy       <= 1'b1;
            state      <= ST_CONV_S;
          end
        end
        ST_CONV_S: begin
          if (iter == ITER_LAST) begin
            score_hold <= shifted[SR_W-1 -: 12];
            shift_reg  <= {12'b0, blood_hold};
            iter       <= '0;
            state      <= ST_CONV_B;
          end else begin
            shift_reg <= shifted;
            iter      <= iter + 1'b1;
          end
        end
        ST_CONV_B: begin
          if (iter == ITER_LAST) begin
            Blood_BCD <= shifted[SR_W-1 -: 12];
            Score_BCD <= score_hold;
            shift_reg <= shifted;
            Valid     <= 1'b1;
            Busy      <= 1'b0;
            iter      <= '0;
            state     <= ST_IDLE;
          end else begin
            shift_reg <= shifted;
            iter      <= iter + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hud_bcd_converter.sv
// Directed and random-frame checks for hud_bcd_converter against a decimal reference.
module tb_hud_bcd_converter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        trig = 1'b0;
  logic [7:0]  Score_In = '0;
  logic [9:0]  Blood_In = '0;
  logic [11:0] Score_BCD;
  logic [11:0] Blood_BCD;
  logic        Valid;
  logic        Busy;
  logic        Overrun;

  int checks = 0;
  int failures = 0;

  hud_bcd_converter dut (
    .Clk                        (Clk),
    .Reset_n                    (Reset_n),
    .game_frame_clk_rising_edge (trig),
    .Score_In                   (Score_In),
    .Blood_In                   (Blood_In),
    .Score_BCD                  (Score_BCD),
    .Blood_BCD                  (Blood_BCD),
    .Valid                      (Valid),
    .Busy                       (Busy),
    .Overrun                    (Overrun)
  );

  always #10 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drives a one-cycle trigger; returns just after the accepting edge (E0).
  task automatic start(input logic [7:0] s, input logic [9:0] b);
    Score_In = s;
    Blood_In = b;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    int c;
    c = (v > 999) ? 999 : v;
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic test_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
    checks++;
    if ({Score_BCD, Blood_BCD, Valid, Busy, Overrun} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {Score_BCD, Blood_BCD, Valid, Busy, Overrun});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({Valid, Busy} !== 2'b00) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d valid_busy got=%b exp=00", i, {Valid, Busy});
      end
    end
  endtask

  task automatic test_basic();
    start(8'd171, 10'd100);
    for (int e = 0; e < 20; e++) begin
      checks++;
      if ({Busy, Valid} !== 2'b10) begin
        failures++;
        $display("FAIL basic_busy E%0d busy_valid got=%b exp=10", e, {Busy, Valid});
      end
      tick();
    end
    checks++;
    if ({Valid, Busy, Score_BCD, Blood_BCD} !== {1'b1, 1'b0, 12'h171, 12'h100}) begin
      failures++;
      $display("FAIL basic_result valid=%b busy=%b score=%h blood=%h exp 1 0 171 100",
               Valid, Busy, Score_BCD, Blood_BCD);
    end
    tick();
    checks++;
    if (Valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_valid_pulse got=%b exp=0", Valid);
    end
  endtask

  task automatic test_clamp();
    start(8'd255, 10'd1023);
    for (int e = 0; e < 20; e++) tick();
    checks++;
    if ({Valid, Score_BCD, Blood_BCD} !== {1'b1, 12'h255, 12'h999}) begin
      failures++;
      $display("FAIL clamp_max valid=%b score=%h blood=%h exp 1 255 999", Valid, Score_BCD, Blood_BCD);
    end
    tick();
    start(8'd0, 10'd0);
    for (int e = 0; e < 10; e++) tick();
    checks++;
    if ({Score_BCD, Blood_BCD} !== {12'h255, 12'h999}) begin
      failures++;
      $display("FAIL hold_mid_conv score=%h blood=%h exp 255 999", Score_BCD, Blood_BCD);
    end
    for (int e = 10; e < 20; e++) tick();
    checks++;
    if ({Valid, Score_BCD, Blood_BCD} !== {1'b1, 12'h000, 12'h000}) begin
      failures++;
      $display("FAIL zero_conv valid=%b score=%h blood=%h exp 1 000 000", Valid, Score_BCD, Blood_BCD);
    end
    tick();
  endtask

  task automatic test_overrun();
    start(8'd9, 10'd50);
    tick();
    Score_In = 8'd200;
    Blood_In = 10'd7;
    for (int e = 1; e < 4; e++) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    checks++;
    if ({Overrun, Busy, Valid} !== 3'b110) begin
      failures++;
      $display("FAIL overrun_e5 ovr_busy_valid got=%b exp=110", {Overrun, Busy, Valid});
    end
    for (int e = 5; e < 19; e++) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    checks++;
    if ({Valid, Overrun, Score_BCD, Blood_BCD} !== {1'b1, 1'b1, 12'h009, 12'h050}) begin
      failures++;
      $display("FAIL overrun_e20 valid=%b ovr=%b score=%h blood=%h exp 1 1 009 050",
               Valid, Overrun, Score_BCD, Blood_BCD);
    end
    start(8'd200, 10'd7);
    checks++;
    if ({Valid, Busy} !== 2'b01) begin
      failures++;
      $display("FAIL accept_e21 valid_busy got=%b exp=01", {Valid, Busy});
    end
    for (int e = 0; e < 20; e++) tick();
    checks++;
    if ({Valid, Overrun, Score_BCD, Blood_BCD} !== {1'b1, 1'b1, 12'h200, 12'h007}) begin
      failures++;
      $display("FAIL after_overrun valid=%b ovr=%b score=%h blood=%h exp 1 1 200 007",
               Valid, Overrun, Score_BCD, Blood_BCD);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    start(8'd42, 10'd42);
    for (int e = 0; e < 20; e++) tick();
    checks++;
    if ({Valid, Score_BCD, Blood_BCD} !== {1'b1, 12'h042, 12'h042}) begin
      failures++;
      $display("FAIL pre_abort valid=%b score=%h blood=%h exp 1 042 042", Valid, Score_BCD, Blood_BCD);
    end
    tick();
    start(8'd99, 10'd99);
    for (int e = 0; e < 11; e++) tick();
    Reset_n = 1'b0;
    tick();
    checks++;
    if ({Score_BCD, Blood_BCD, Valid, Busy, Overrun} !== 27'd0) begin
      failures++;
      $display("FAIL abort_reset got=%h exp=0", {Score_BCD, Blood_BCD, Valid, Busy, Overrun});
    end
    Reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({Valid, Busy} !== 2'b00) begin
        failures++;
        $display("FAIL abort_no_valid cyc=%0d valid_busy got=%b exp=00", i, {Valid, Busy});
      end
    end
    start(8'd99, 10'd99);
    for (int e = 0; e < 20; e++) tick();
    checks++;
    if ({Valid, Score_BCD, Blood_BCD} !== {1'b1, 12'h099, 12'h099}) begin
      failures++;
      $display("FAIL post_abort valid=%b score=%h blood=%h exp 1 099 099", Valid, Score_BCD, Blood_BCD);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int s;
    int b;
    for (int f = 0; f < 50; f++) begin
      s = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 1023));
      if (f == 0) b = 1000;
      if (f == 1) b = 999;
      start(8'(s), 10'(b));
      for (int e = 0; e < 20; e++) tick();
      checks++;
      if ({Valid, Score_BCD, Blood_BCD} !== {1'b1, ref_bcd(s), ref_bcd(b)}) begin
        failures++;
        $display("FAIL frame%0d in=%0d/%0d valid=%b score=%h blood=%h exp 1 %h %h",
                 f, s, b, Valid, Score_BCD, Blood_BCD, ref_bcd(s), ref_bcd(b));
      end
    end
    checks++;
    if (Overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_overrun got=%b exp=0", Overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_overrun();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
